// File: rtl/csa_pipe_addsub.sv
// rtl/csa_pipe_addsub.sv - pipelined carry-select adder/subtractor with valid/ready handshake
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake; in_ready equals the global advance enable
//   din1, din2           operands A and B
//   carry_in, sub        carry in (borrow in when subtracting), 0 = add / 1 = subtract
//   out_valid, out_ready result handshake
//   dout                 sum or difference
//   carry_out            carry out of the MSB (1 = no borrow when subtracting)
//   overflow             two's-complement signed overflow
//   zero                 dout == 0
module csa_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NB   = WIDTH / BLOCK;
    localparam int SEG  = NB / STAGES;
    localparam int SEGW = SEG * BLOCK;

    // Entry k holds the state leaving stage k. Operands are kept at their
    // original bit positions; only the bits above the resolved boundary matter.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;
    logic              zero_q;
    logic              en;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES-1];
    assign dout      = r_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    // Resolve one segment of SEG blocks. The very first block of the word
    // ripples with the effective carry-in; every other block precomputes both
    // carry-in outcomes and selects on the incoming block carry.
    function automatic logic [SEGW:0] resolve_seg(
        input logic [SEGW-1:0] a,
        input logic [SEGW-1:0] b,
        input logic            cin,
        input logic            ripple_first
    );
        logic [SEGW-1:0] s;
        logic [BLOCK:0]  s0;
        logic [BLOCK:0]  s1;
        logic            c;
        c = cin;
        s = '0;
        for (int j = 0; j < SEG; j++) begin
            s0 = {1'b0, a[j*BLOCK +: BLOCK]} + {1'b0, b[j*BLOCK +: BLOCK]};
            if (ripple_first && j == 0) begin
                s0 = s0 + {{BLOCK{1'b0}}, c};
                s1 = s0;
            end else begin
                s1 = s0 + {{BLOCK{1'b0}}, 1'b1};
            end
            {c, s[j*BLOCK +: BLOCK]} = c ? s1 : s0;
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEGW;

        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_r;
        logic             src_c;
        logic             src_v;
        logic [SEGW:0]    seg;
        logic [WIDTH-1:0] nxt_r;

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + ~borrow_in.
            assign src_a = din1;
            assign src_b = din2 ^ {WIDTH{sub}};
            assign src_r = '0;
            assign src_c = carry_in ^ sub;
            assign src_v = in_valid && in_ready;
        end else begin : g_next
            assign src_a = a_q[k-1];
            assign src_b = b_q[k-1];
            assign src_r = r_q[k-1];
            assign src_c = c_q[k-1];
            assign src_v = v_q[k-1];
        end

        assign seg = resolve_seg(src_a[LO +: SEGW], src_b[LO +: SEGW], src_c, k == 0);

        always_comb begin
            nxt_r = src_r;
            nxt_r[LO +: SEGW] = seg[SEGW-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (en) begin
                v_q[k] <= src_v;
                r_q[k] <= nxt_r;
                c_q[k] <= seg[SEGW];
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                a_q[k] <= src_a;
                b_q[k] <= src_b;
            end
        end

        if (k == STAGES - 1) begin : g_last
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    ovf_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ nxt_r[WIDTH-1] ^ seg[SEGW];
                    zero_q <= (nxt_r == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_pipe_addsub.sv
// tb/tb_csa_pipe_addsub.sv - self-checking bench for csa_pipe_addsub (32/8/2 directed, 16/4/4 random)
module tb_csa_pipe_addsub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32;
    logic        cout32, ovf32, zero32;
    logic [31:0] a32, b32, dout32;

    logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16;
    logic        cout16, ovf16, zero16;
    logic [15:0] a16, b16, dout16;

    csa_pipe_addsub #(.WIDTH(32), .BLOCK(8), .STAGES(2)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .din1(a32), .din2(b32), .carry_in(cin32), .sub(sub32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .dout(dout32), .carry_out(cout32), .overflow(ovf32), .zero(zero32)
    );

    csa_pipe_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .din1(a16), .din2(b16), .carry_in(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .dout(dout16), .carry_out(cout16), .overflow(ovf16), .zero(zero16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: exact integer arithmetic. Returns {zero, overflow, carry_out, result}.
    function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint m, ua, ub, ut, sa, sb, st;
        logic [31:0] r;
        logic co, ov;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        ut = sub ? (ua - ub - longint'(cin)) : (ua + ub + longint'(cin));
        co = sub ? (ut >= 0) : (ut >= m);
        r  = 32'(ut & (m - 1));
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        st = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
        ov = (st < -(m / 2)) || (st >= m / 2);
        return {r == 32'd0, ov, co, r};
    endfunction

    // Scoreboards: push on accepted input, pop on accepted output.
    logic [34:0] q32[$];
    logic [34:0] q16[$];
    int pushes32 = 0, pops32 = 0, pushes16 = 0, pops16 = 0;
    logic        stall32 = 1'b0, stall16 = 1'b0;
    logic [34:0] held32, held16;

    always @(negedge clk) begin
        logic [34:0] e;
        if (rst) begin
            q32.delete();
            stall32 = 1'b0;
        end else begin
            if (stall32)
                check("hold32", {out_valid32, zero32, ovf32, cout32, dout32}, {1'b1, held32});
            if (in_valid32 && in_ready32) begin
                q32.push_back(model(32, a32, b32, cin32, sub32));
                pushes32++;
            end
            if (out_valid32 && out_ready32) begin
                check("q32_nonempty", q32.size() != 0, 1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    check("dout32", dout32, e[31:0]);
                    check("flags32", {zero32, ovf32, cout32}, e[34:32]);
                end
                pops32++;
            end
            stall32 = out_valid32 && !out_ready32;
            held32  = {zero32, ovf32, cout32, dout32};
        end
    end

    always @(negedge clk) begin
        logic [34:0] e;
        if (rst) begin
            q16.delete();
            stall16 = 1'b0;
        end else begin
            if (stall16)
                check("hold16", {out_valid16, zero16, ovf16, cout16, dout16}, {1'b1, held16[34:32], held16[15:0]});
            if (in_valid16 && in_ready16) begin
                q16.push_back(model(16, {16'h0, a16}, {16'h0, b16}, cin16, sub16));
                pushes16++;
            end
            if (out_valid16 && out_ready16) begin
                check("q16_nonempty", q16.size() != 0, 1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("dout16", dout16, e[15:0]);
                    check("flags16", {zero16, ovf16, cout16}, e[34:32]);
                end
                pops16++;
            end
            stall16 = out_valid16 && !out_ready16;
            held16  = {zero16, ovf16, cout16, 16'h0, dout16};
        end
    end

    // Directed single op on the 32-bit instance; entered and left at posedge+1.
    task automatic run_op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic [31:0] exp_d,
                            input logic exp_c, input logic exp_o, input logic exp_z);
        in_valid32 = 1'b1; a32 = a; b32 = b; cin32 = cin; sub32 = sub;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        @(negedge clk);
        check({tag, "_latency"}, out_valid32, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_valid"}, out_valid32, 1);
        check({tag, "_dout"}, dout32, exp_d);
        check({tag, "_cout_ovf_zero"}, {cout32, ovf32, zero32}, {exp_c, exp_o, exp_z});
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_push, base_pop;
        rst = 1'b1;
        in_valid32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; out_ready32 = 1;
        in_valid16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; out_ready16 = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid32", out_valid32, 0);
        check("rst_in_ready32", in_ready32, 1);
        check("rst_outputs32", {dout32, cout32, ovf32, zero32}, 0);
        check("rst_out_valid16", out_valid16, 0);
        check("rst_in_ready16", in_ready16, 1);
        @(posedge clk); #1;

        run_op32("add_ovf",   32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0);
        run_op32("wrap",      32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1);
        run_op32("blk_carry", 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 0);
        run_op32("stg_carry", 32'h00FFFFFF, 32'h00000001, 0, 0, 32'h01000000, 0, 0, 0);
        run_op32("sub_neg",   32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0, 0);
        run_op32("sub_ovf",   32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0);
        run_op32("sub_borin", 32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFD, 0, 0, 0);
        run_op32("add_cin",   32'h0000FFFF, 32'h00000000, 1, 0, 32'h00010000, 0, 0, 0);

        // Backpressure: A, B, C back to back, two stall cycles once A is at the output.
        base_push = pushes32; base_pop = pops32;
        in_valid32 = 1; a32 = 32'h11111111; b32 = 32'h22222222; cin32 = 0; sub32 = 0;
        @(posedge clk); #1;
        a32 = 32'h40000000; b32 = 32'h01000000; sub32 = 1;
        @(posedge clk); #1;
        out_ready32 = 0; a32 = 32'hDEADBEEF; b32 = 32'h21524111; sub32 = 0;
        @(negedge clk);
        check("bp_valid", out_valid32, 1);
        check("bp_dout_a", dout32, 32'h33333333);
        check("bp_in_ready", in_ready32, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_dout_a_held", dout32, 32'h33333333);
        check("bp_in_ready_held", in_ready32, 0);
        @(posedge clk); #1;
        out_ready32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0;
        repeat (6) @(posedge clk);
        #1;
        check("bp_accepted", pushes32 - base_push, 3);
        check("bp_emerged", pops32 - base_pop, 3);

        // Reset with two ops in flight: neither may ever be delivered.
        out_ready32 = 0; in_valid32 = 1; a32 = 32'h12345678; b32 = 32'h00000001; sub32 = 0;
        @(posedge clk); #1;
        a32 = 32'hCAFEF00D;
        @(posedge clk); #1;
        in_valid32 = 0; rst = 1;
        base_pop = pops32;
        @(posedge clk); #1;
        rst = 0; out_ready32 = 1;
        @(negedge clk);
        check("midrst_out_valid", out_valid32, 0);
        check("midrst_in_ready", in_ready32, 1);
        check("midrst_dout", dout32, 0);
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_emerge", pops32 - base_pop, 0);

        // 16/4/4: 10k random operations with random backpressure.
        begin
            int cyc = 0;
            while (pushes16 < 10000 && cyc < 60000) begin
                in_valid16  = ($urandom_range(0, 3) != 0);
                a16         = pick16();
                b16         = pick16();
                cin16       = 1'($urandom_range(0, 1));
                sub16       = 1'($urandom_range(0, 1));
                out_ready16 = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                cyc++;
            end
        end
        in_valid16 = 0; out_ready16 = 1;
        repeat (12) @(posedge clk);
        #1;
        check("rand_accepted", pushes16, 10000);
        check("rand_emerged", pops16, 10000);
        check("rand_drained", q16.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csa_pipe_addsub.md
CSA_PIPE_ADDSUB -- requirements
Module: csa_pipe_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; must be a multiple of BLOCK.
REQ-002 SHALL provide parameter BLOCK, default 8, carry-select block width in bits.
REQ-003 SHALL provide parameter STAGES, default 2, register stages; must divide NB = WIDTH/BLOCK, 1 <= STAGES <= NB.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port in_valid  input  1  operand set valid.
REQ-007 SHALL provide port in_ready  output  1  block accepts the operand set this cycle.
REQ-008 SHALL provide port din1  input  WIDTH  operand A.
REQ-009 SHALL provide port din2  input  WIDTH  operand B.
REQ-010 SHALL provide port carry_in  input  1  carry in for add; borrow in for subtract.
REQ-011 SHALL provide port sub  input  1  0 = add, 1 = subtract.
REQ-012 SHALL provide port out_valid  output  1  result valid.
REQ-013 SHALL provide port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL provide port dout  output  WIDTH  sum or difference.
REQ-015 SHALL provide port carry_out  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-016 SHALL provide port overflow  output  1  two's-complement signed overflow.
REQ-017 SHALL provide port zero  output  1  dout == 0.

Function
REQ-018 SHALL compute din1 + (din2 XOR {WIDTH{sub}}) + (carry_in XOR sub), modulo 2^WIDTH; the carry-out is carry_out.
REQ-019 SHALL ripple block 0 with the effective carry-in; every higher block SHALL precompute the cin=0 and cin=1 sums and carries, then mux them on the incoming block carry.
REQ-020 SHALL split the NB blocks into STAGES contiguous segments of NB/STAGES blocks each, LSB segment first; segment k SHALL resolve in pipeline stage k.
REQ-021 SHALL register, per stage: valid bit, resolved low result bits, the segment carry, and the unresolved upper operand bits (already sub-inverted).
REQ-022 SHALL set overflow = carry into MSB XOR carry_out, computed in the final stage.
REQ-023 SHALL compute zero from the final dout.
REQ-024 SHALL register dout, carry_out, overflow and zero at the final stage.
REQ-025 Latency: an operand set accepted at edge N SHALL appear with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles later.
REQ-026 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-027 Handshake SHALL use a global advance enable en = !out_valid || out_ready.
REQ-028 in_ready SHALL equal en.
REQ-029 A transfer SHALL occur only when in_valid && in_ready.
REQ-030 When en=1, every stage SHALL load from its predecessor; stage 0 SHALL load the valid bit in_valid && in_ready.
REQ-031 When en=0, all stage registers SHALL hold; dout, carry_out, overflow and zero SHALL stay stable while out_valid && !out_ready.
REQ-032 Results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-033 Bubbles (invalid stages) are not collapsed.
REQ-034 Datapath registers of invalid stages SHALL be don't-care, except at the output (REQ-036).
REQ-035 Inputs SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-036 While rst=1 at a clock edge, all stage valid bits SHALL clear and dout, carry_out, overflow and zero SHALL reset to 0.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight results.
REQ-038 out_valid SHALL be 0 in the cycle after the reset edge.
REQ-039 No pre-reset result SHALL ever appear after reset.
REQ-040 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-041 Bench SHALL cover add overflow (WIDTH=32, BLOCK=8, STAGES=2, out_ready=1): 0x7FFFFFFF + 0x00000001, cin=0 -> two cycles later dout=0x80000000, overflow=1, carry_out=0, zero=0.
REQ-042 Bench SHALL cover wrap-around: 0xFFFFFFFF + 0x00000001 -> dout=0x00000000, carry_out=1, overflow=0, zero=1.
REQ-043 Bench SHALL cover block-boundary carry select: 0x000000FF + 0x00000001 -> 0x00000100; 0x00FFFFFF + 0x00000001 crossing the stage boundary -> 0x01000000.
REQ-044 Bench SHALL cover subtract:
- 5 - 7, cin=0 -> dout=0xFFFFFFFE, carry_out=0, overflow=0.
- 0x80000000 - 1 -> dout=0x7FFFFFFF, carry_out=1, overflow=1.
- 5 - 7 with cin=1 -> dout=0xFFFFFFFD.
REQ-045 Bench SHALL cover backpressure: stream A, B, C back-to-back, out_ready=0 for two cycles once A is valid -> in_ready=0 and dout holds A during the stall; A, B, C then emerge in order with no loss.
REQ-046 Bench SHALL cover reset and a parameter sweep:
- rst=1 for one cycle with two ops in flight -> out_valid=0 next cycle, and neither op ever emerges.
- WIDTH=16, BLOCK=4, STAGES=4: 10k random ops vs a behavioral model, with random out_ready.
